frmbuf_rd: RTL

FRMBUF_RD -- requirements
Module: frmbuf_rd

---
 rtl/frmbuf_pkg.sv | 26 ++
 rtl/frmbuf_vsyn_edge.sv | 26 ++
 rtl/frmbuf_rd.sv | 138 +++++++++++++
 3 files changed

// File: rtl/frmbuf_pkg.sv
// Shared definitions for the frame-buffer reader and writer: state encodings,
// burst defaults, DDR app command codes and bus widths.
package frmbuf_pkg;

    localparam int unsigned ADDR_W       = 27;
    localparam int unsigned DATA_W       = 256;
    localparam int unsigned CMD_W        = 3;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned PEND_W       = 6;
    localparam int unsigned VS_SHIFT_W   = 10;

    localparam int unsigned RD_NUM_DEF   = 32;
    localparam int unsigned ADDR_ADD_DEF = 8;

    localparam logic [CMD_W-1:0] APP_CMD_WR = 3'd0;
    localparam logic [CMD_W-1:0] APP_CMD_RD = 3'd1;

    typedef enum logic [STATE_W-1:0] {
        S_idle     = 3'd0,
        S_wait_buf = 3'd1,
        S_arb_req  = 3'd2,
        S_rd_cmd   = 3'd3,
        S_rd_wait  = 3'd4
    } state_t;

endpackage

// File: rtl/frmbuf_vsyn_edge.sv
// Brings the asynchronous vsync into the DDR clock domain and emits a
// registered one-cycle pulse on its falling edge.
module frmbuf_vsyn_edge
    import frmbuf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic vsyn,
    output logic vs_fall
);

    logic [VS_SHIFT_W-1:0] vs_shift;

    // Long shift chain doubles as synchroniser and glitch filter; the edge is
    // taken from the two oldest taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_shift <= '0;
            vs_fall  <= 1'b0;
        end else begin
            vs_shift <= {vs_shift[VS_SHIFT_W-2:0], vsyn};
            vs_fall  <= (vs_shift[VS_SHIFT_W-1 -: 2] == 2'b10);
        end
    end

endmodule

// File: rtl/frmbuf_rd.sv
// Frame-buffer reader: arbitrates for the DDR, issues bursts of read commands
// from the frame base address and streams returned beats into the display FIFO.
module frmbuf_rd
    import frmbuf_pkg::*;
#(
    parameter int unsigned p_debug_en = 0,
    parameter int unsigned p_rd_num   = RD_NUM_DEF,
    parameter int unsigned p_addr_add = ADDR_ADD_DEF
) (
    input  logic              i_ddr3_clk,
    input  logic              i_rst_n,
    input  logic              i_system_init,
    input  logic              i_dst_vsyn,
    input  logic [ADDR_W-1:0] i_addr_inital,
    input  logic              i_fifo_almost_full,
    output logic              o_fifo_rst,
    output logic              o_fifo_wr,
    output logic [DATA_W-1:0] o_fifo_data,
    output logic              o_request,
    input  logic              i_response,
    output logic              o_bust_end,
    output logic              o_app_en,
    output logic [CMD_W-1:0]  o_app_cmd,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_app_rdy,
    input  logic [DATA_W-1:0] i_app_rd_data,
    input  logic              i_app_rd_data_valid,
    output logic [STATE_W-1:0] o_cs,
    output logic [STATE_W-1:0] o_ns
);

    localparam int unsigned       CNT_W     = $clog2(p_rd_num + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(p_rd_num - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(p_addr_add);

    state_t              cs;
    state_t              ns;
    logic                vs_fall;
    logic                accept;
    logic                in_burst;
    logic [CNT_W-1:0]    cmd_cnt;
    logic [CNT_W-1:0]    data_cnt;
    logic [PEND_W-1:0]   pending;

    frmbuf_vsyn_edge u_vsyn_edge (
        .clk     (i_ddr3_clk),
        .rst_n   (i_rst_n),
        .vsyn    (i_dst_vsyn),
        .vs_fall (vs_fall)
    );

    assign in_burst    = (cs == S_rd_cmd) || (cs == S_rd_wait);
    assign o_app_en    = (cs == S_rd_cmd);
    assign accept      = o_app_en && i_app_rdy;
    assign o_app_cmd   = APP_CMD_RD;
    // Beats returning in S_idle belong to an aborted burst and are discarded.
    assign o_fifo_wr   = i_app_rd_data_valid && in_burst;
    assign o_fifo_data = i_app_rd_data;
    assign o_fifo_rst  = vs_fall;
    assign o_cs        = cs;
    assign o_ns        = ns;

    // Next-state logic; a vsync falling edge aborts from any state.
    always_comb begin
        ns = cs;
        case (cs)
            S_idle:     if (i_system_init && (pending == '0)) ns = S_wait_buf;
            S_wait_buf: if (!i_fifo_almost_full)               ns = S_arb_req;
            S_arb_req:  if (i_response)                        ns = S_rd_cmd;
            S_rd_cmd:   if (accept && (cmd_cnt == LAST_IDX))   ns = S_rd_wait;
            S_rd_wait:  if (i_app_rd_data_valid && (data_cnt == LAST_IDX)) ns = S_idle;
            default:    ns = S_idle;
        endcase
        if (vs_fall) begin
            ns = S_idle;
        end
    end

    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs         <= S_idle;
            o_request  <= 1'b0;
            o_bust_end <= 1'b0;
        end else begin
            cs         <= ns;
            o_request  <= (cs == S_arb_req);
            o_bust_end <= (cs == S_rd_wait) && (ns == S_idle) && !vs_fall;
        end
    end

    // Command address: rebased each frame, advanced only on accepted commands.
    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr <= '0;
        end else if (vs_fall) begin
            o_addr <= i_addr_inital;
        end else if (accept) begin
            o_addr <= o_addr + ADDR_STEP;
        end
    end

    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_cnt  <= '0;
            data_cnt <= '0;
        end else begin
            if (cs != S_rd_cmd) begin
                cmd_cnt <= '0;
            end else if (accept) begin
                cmd_cnt <= cmd_cnt + CNT_W'(1);
            end
            if (cs == S_idle) begin
                data_cnt <= '0;
            end else if (in_burst && i_app_rd_data_valid) begin
                data_cnt <= data_cnt + CNT_W'(1);
            end
        end
    end

    // Reads in flight at the DDR; a new burst waits until stale data has drained.
    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
        end else begin
            case ({accept, i_app_rd_data_valid})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    if (p_debug_en != 0) begin : g_debug
        pend_no_wrap: assert property (@(posedge i_ddr3_clk) disable iff (!i_rst_n)
            !(accept && !i_app_rd_data_valid && (pending == '1)));
    end

endmodule
